// File: rtl/ama_riscv_fetch_dp_if.sv
// ---------------------------------------------------------------------------
// ama_riscv_fetch_dp_if
// Instruction-memory request/response bundle between the fetch datapath,
// the fetch controller (which drives the valid/ready qualifiers) and imem.
//
// Signals:
//   imem_req_valid  request valid (driven by fe_ctrl)
//   imem_req_ready  imem accepts the request
//   imem_req_addr   request byte address (driven by the fetch datapath)
//   imem_rsp_valid  imem response valid
//   imem_rsp_ready  response ready (driven by fe_ctrl)
//   imem_rsp_data   fetched instruction word
//
// Modports:
//   master  fetch-datapath view (drives the address, observes everything else)
//   slave   memory/controller view
// ---------------------------------------------------------------------------
interface ama_riscv_fetch_dp_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic        imem_rsp_ready;
  logic [31:0] imem_rsp_data;

  modport master (
    input  imem_req_valid,
    input  imem_req_ready,
    output imem_req_addr,
    input  imem_rsp_valid,
    input  imem_rsp_ready,
    input  imem_rsp_data
  );

  modport slave (
    output imem_req_valid,
    output imem_req_ready,
    input  imem_req_addr,
    output imem_rsp_valid,
    output imem_rsp_ready,
    output imem_rsp_data
  );
endinterface

// File: rtl/ama_riscv_fetch_dp.sv
// ---------------------------------------------------------------------------
// ama_riscv_fetch_dp
// Fetch-stage datapath: PC register, single-outstanding imem request tracker
// (IDLE / WAIT / FLUSH), fetched-instruction register toward decode, bubble
// injection and a sticky protocol-error flag.
//
// Optional build macro:
//   FETCH_PERF_CNT_EN  adds 32-bit wrapping counters cnt_fetched (captured
//                      responses) and cnt_dropped (responses discarded in
//                      FLUSH) plus their output ports.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   pc_sel          00 hold, 01 PC+4, 10 alu_out, 11 hold
//   pc_we           PC register write enable
//   bubble_dec      present NOP_INST to decode this cycle
//   alu_out         branch/jump target from execute
//   imem            imem request/response bundle (master modport)
//   inst_dec        instruction to decode
//   pc_dec          PC of inst_dec
//   inst_dec_valid  inst_dec is a live, non-bubble instruction
//   cnt_fetched     (FETCH_PERF_CNT_EN only) captured responses
//   cnt_dropped     (FETCH_PERF_CNT_EN only) discarded stale responses
//   fetch_err       sticky protocol-error flag
// ---------------------------------------------------------------------------
module ama_riscv_fetch_dp #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST  = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            pc_sel,
  input  logic                  pc_we,
  input  logic                  bubble_dec,
  input  logic [31:0]           alu_out,
  ama_riscv_fetch_dp_if.master  imem,
  output logic [31:0]           inst_dec,
  output logic [31:0]           pc_dec,
  output logic                  inst_dec_valid,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]           cnt_fetched,
  output logic [31:0]           cnt_dropped,
`endif
  output logic                  fetch_err
);

  // Request-tracker states
  localparam logic [1:0] S_IDLE  = 2'b00;  // nothing outstanding
  localparam logic [1:0] S_WAIT  = 2'b01;  // one live request outstanding
  localparam logic [1:0] S_FLUSH = 2'b10;  // one stale request outstanding

  localparam logic [1:0] PC_SEL_INC = 2'b01;
  localparam logic [1:0] PC_SEL_ALU = 2'b10;

  logic [31:0] r_pc;
  logic [31:0] r_req_pc;
  logic [1:0]  r_state;
  logic [31:0] r_inst_q;
  logic [31:0] r_pc_q;
  logic        r_live_q;
  logic        r_fetch_err;

  logic        w_req_fire;
  logic        w_rsp_fire;
  logic        w_redirect;
  logic [31:0] w_pc_nxt;
  logic [1:0]  w_state_nxt;
  logic        w_capture;
  logic        w_drop;
  logic        w_err_set;

  assign w_req_fire = imem.imem_req_valid & imem.imem_req_ready;
  assign w_rsp_fire = imem.imem_rsp_valid & imem.imem_rsp_ready;
  assign w_redirect = pc_we & (pc_sel == PC_SEL_ALU);

  // Next PC. The 11 encoding is reserved and behaves as hold.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_pc_nxt = r_pc;
    case (pc_sel)
      PC_SEL_INC: w_pc_nxt = r_pc + 32'd4;                 // wraps at 2^32
      PC_SEL_ALU: w_pc_nxt = {alu_out[31:1], 1'b0};        // JALR-style LSB clear
      default:    w_pc_nxt = r_pc;
    endcase
  end

  // Outstanding-request tracker
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_drop      = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      S_IDLE: begin
        // A response with nothing outstanding is a protocol error; it is dropped.
        if (w_rsp_fire) w_err_set = 1'b1;
        if (w_req_fire) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (w_rsp_fire) begin
          // A redirect in the same cycle does not flush: this response belongs
          // to the stream fe_ctrl has already resolved.
          w_capture   = 1'b1;
          w_state_nxt = w_req_fire ? S_WAIT : S_IDLE;
        end else begin
          // Second request while one is still outstanding.
          if (w_req_fire) w_err_set = 1'b1;
          if (w_redirect) w_state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (w_rsp_fire) begin
          w_drop      = 1'b1;
          w_state_nxt = w_req_fire ? S_WAIT : S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc        <= RESET_VEC;
      r_req_pc    <= RESET_VEC;
      r_state     <= S_IDLE;
      r_inst_q    <= NOP_INST;
      r_pc_q      <= RESET_VEC;
      r_live_q    <= 1'b0;
      r_fetch_err <= 1'b0;
    end else begin
      if (pc_we)      r_pc     <= w_pc_nxt;
      if (w_req_fire) r_req_pc <= r_pc;
      r_state <= w_state_nxt;
      // Without a capture the decode-side registers hold, so a stall keeps the instruction.
      if (w_capture) begin
        r_inst_q <= imem.imem_rsp_data;
        r_pc_q   <= r_req_pc;
        r_live_q <= 1'b1;
      end
      if (w_err_set) r_fetch_err <= 1'b1;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_cnt_fetched;
  logic [31:0] r_cnt_dropped;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_fetched <= 32'd0;
      r_cnt_dropped <= 32'd0;
    end else begin
      if (w_capture) r_cnt_fetched <= r_cnt_fetched + 32'd1;
      if (w_drop)    r_cnt_dropped <= r_cnt_dropped + 32'd1;
    end
  end

  assign cnt_fetched = r_cnt_fetched;
  assign cnt_dropped = r_cnt_dropped;
`endif

  assign imem.imem_req_addr = r_pc;
  assign inst_dec           = bubble_dec ? NOP_INST : r_inst_q;
  assign pc_dec             = r_pc_q;
  assign inst_dec_valid     = r_live_q & ~bubble_dec;
  assign fetch_err          = r_fetch_err;

endmodule

// File: tb/tb_ama_riscv_fetch_dp.sv
// ---------------------------------------------------------------------------
// tb_ama_riscv_fetch_dp
// Self-checking bench for ama_riscv_fetch_dp: a directed vector table for the
// basic fetch stream, flush, redirect/response overlap and bubbles; a
// randomized run against a transaction-level reference model; and short
// hand-written sequences for PC wrap, reset mid-request and protocol errors.
// Build with +define+FETCH_PERF_CNT_EN to also check the counters.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ama_riscv_fetch_dp;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  pc_sel;
  logic        pc_we;
  logic        bubble_dec;
  logic [31:0] alu_out;
  logic [31:0] inst_dec;
  logic [31:0] pc_dec;
  logic        inst_dec_valid;
  logic        fetch_err;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] cnt_fetched;
  logic [31:0] cnt_dropped;
`endif

  ama_riscv_fetch_dp_if imem_if ();

  ama_riscv_fetch_dp dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_sel         (pc_sel),
    .pc_we          (pc_we),
    .bubble_dec     (bubble_dec),
    .alu_out        (alu_out),
    .imem           (imem_if.master),
    .inst_dec       (inst_dec),
    .pc_dec         (pc_dec),
    .inst_dec_valid (inst_dec_valid),
`ifdef FETCH_PERF_CNT_EN
    .cnt_fetched    (cnt_fetched),
    .cnt_dropped    (cnt_dropped),
`endif
    .fetch_err      (fetch_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change one time unit after the rising edge; outputs are read after that.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    pc_sel                 = 2'b00;
    pc_we                  = 1'b0;
    bubble_dec             = 1'b0;
    alu_out                = 32'h0;
    imem_if.imem_req_valid = 1'b0;
    imem_if.imem_req_ready = 1'b1;
    imem_if.imem_rsp_valid = 1'b0;
    imem_if.imem_rsp_ready = 1'b1;
    imem_if.imem_rsp_data  = 32'h0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_addr"},  imem_if.imem_req_addr, 32'h0);
    check({tag, "_inst"},  inst_dec, NOP);
    check({tag, "_pc"},    pc_dec, 32'h0);
    check({tag, "_valid"}, {31'd0, inst_dec_valid}, 32'd0);
    check({tag, "_err"},   {31'd0, fetch_err}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    check({tag, "_cntf"},  cnt_fetched, 32'd0);
    check({tag, "_cntd"},  cnt_dropped, 32'd0);
`endif
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [1:0]  sel;
    logic        we;
    logic        bub;
    logic [31:0] alu;
    logic        qv;
    logic        sv;
    logic [31:0] data;
    logic [31:0] e_addr;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
    logic        e_valid;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] sel, input logic we, input logic bub,
                              input logic [31:0] alu, input logic qv, input logic sv,
                              input logic [31:0] data, input logic [31:0] e_addr,
                              input logic [31:0] e_inst, input logic [31:0] e_pc,
                              input logic e_valid);
    vec_t v;
    v.sel = sel; v.we = we; v.bub = bub; v.alu = alu; v.qv = qv; v.sv = sv;
    v.data = data; v.e_addr = e_addr; v.e_inst = e_inst; v.e_pc = e_pc; v.e_valid = e_valid;
    return v;
  endfunction

  // ---------------- transaction-level reference model ----------------
  typedef struct {
    logic [31:0] addr;
    bit          stale;
  } req_t;

  req_t        m_q[$];
  logic [31:0] m_pc, m_inst, m_pcq;
  bit          m_live, m_err;
  int unsigned m_fetched, m_dropped;

  task automatic model_reset();
    m_q.delete();
    m_pc = 32'h0; m_inst = NOP; m_pcq = 32'h0;
    m_live = 1'b0; m_err = 1'b0; m_fetched = 0; m_dropped = 0;
  endtask

  // Applies one clock edge worth of the currently driven inputs.
  task automatic model_step();
    bit   rsp_f, req_f, redir;
    req_t r;
    rsp_f = imem_if.imem_rsp_valid && imem_if.imem_rsp_ready;
    req_f = imem_if.imem_req_valid && imem_if.imem_req_ready;
    redir = pc_we && (pc_sel == 2'b10);
    if (rsp_f) begin
      if (m_q.size() == 0) m_err = 1'b1;
      else begin
        r = m_q.pop_front();
        if (r.stale) m_dropped++;
        else begin
          m_inst = imem_if.imem_rsp_data; m_pcq = r.addr; m_live = 1'b1; m_fetched++;
        end
      end
    end else if (redir) begin
      foreach (m_q[k]) m_q[k].stale = 1'b1;
    end
    if (req_f) begin
      r.addr = m_pc; r.stale = 1'b0;
      m_q.push_back(r);
    end
    if (pc_we) begin
      if (pc_sel == 2'b01) m_pc = m_pc + 32'd4;
      else if (pc_sel == 2'b10) m_pc = alu_out & 32'hFFFF_FFFE;
    end
  endtask

  initial begin
    vec_t vt[12];
    logic [31:0] d0, d1, d2, d3;
    d0 = 32'h0010_0093; d1 = 32'h0020_0113; d2 = 32'h0030_0193; d3 = 32'h0040_0213;

    //          sel    we    bub   alu           qv    sv    data          addr          inst  pc            valid
    vt[0]  = mk(2'd1, 1'b1, 1'b0, 32'h0,       1'b1, 1'b0, 32'h0,        32'h4,        NOP,  32'h0,        1'b0);
    vt[1]  = mk(2'd1, 1'b1, 1'b0, 32'h0,       1'b1, 1'b1, d0,           32'h8,        d0,   32'h0,        1'b1);
    vt[2]  = mk(2'd1, 1'b1, 1'b0, 32'h0,       1'b1, 1'b1, d1,           32'hC,        d1,   32'h4,        1'b1);
    vt[3]  = mk(2'd0, 1'b0, 1'b0, 32'h0,       1'b0, 1'b1, d2,           32'hC,        d2,   32'h8,        1'b1);
    vt[4]  = mk(2'd0, 1'b0, 1'b1, 32'h0,       1'b0, 1'b0, 32'h0,        32'hC,        NOP,  32'h8,        1'b0);
    vt[5]  = mk(2'd0, 1'b0, 1'b0, 32'h0,       1'b0, 1'b0, 32'h0,        32'hC,        d2,   32'h8,        1'b1);
    vt[6]  = mk(2'd1, 1'b1, 1'b0, 32'h0,       1'b0, 1'b0, 32'h0,        32'h10,       d2,   32'h8,        1'b1);
    vt[7]  = mk(2'd0, 1'b0, 1'b0, 32'h0,       1'b1, 1'b0, 32'h0,        32'h10,       d2,   32'h8,        1'b1);
    vt[8]  = mk(2'd2, 1'b1, 1'b0, 32'h101,     1'b0, 1'b0, 32'h0,        32'h100,      d2,   32'h8,        1'b1);
    vt[9]  = mk(2'd0, 1'b0, 1'b0, 32'h0,       1'b0, 1'b1, 32'hDEADBEEF, 32'h100,      d2,   32'h8,        1'b1);
    vt[10] = mk(2'd1, 1'b1, 1'b0, 32'h0,       1'b1, 1'b0, 32'h0,        32'h104,      d2,   32'h8,        1'b1);
    vt[11] = mk(2'd2, 1'b1, 1'b0, 32'h200,     1'b0, 1'b1, d3,           32'h200,      d3,   32'h100,      1'b1);

    // ---- reset state ----
    do_reset();
    check_reset_state("rst");

    // ---- table: stream, bubble, flush, redirect overlapping a response ----
    for (int i = 0; i < 12; i++) begin
      pc_sel = vt[i].sel; pc_we = vt[i].we; bubble_dec = vt[i].bub; alu_out = vt[i].alu;
      imem_if.imem_req_valid = vt[i].qv;
      imem_if.imem_rsp_valid = vt[i].sv;
      imem_if.imem_rsp_data  = vt[i].data;
      tick();
      check($sformatf("vec%0d_addr", i),  imem_if.imem_req_addr, vt[i].e_addr);
      check($sformatf("vec%0d_inst", i),  inst_dec, vt[i].e_inst);
      check($sformatf("vec%0d_pc", i),    pc_dec, vt[i].e_pc);
      check($sformatf("vec%0d_valid", i), {31'd0, inst_dec_valid}, {31'd0, vt[i].e_valid});
      check($sformatf("vec%0d_err", i),   {31'd0, fetch_err}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
      if (i == 9) begin
        check("cnt_fetched_3", cnt_fetched, 32'd3);
        check("cnt_dropped_1", cnt_dropped, 32'd1);
      end
`endif
    end
    drive_idle();

    // ---- randomized run against the reference model ----
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      bit rsp_f;
      pc_we      = ($urandom_range(0, 3) != 0);
      pc_sel     = 2'($urandom_range(0, 3));
      alu_out    = $urandom;
      bubble_dec = ($urandom_range(0, 4) == 0);
      imem_if.imem_rsp_valid = (m_q.size() != 0) && ($urandom_range(0, 2) == 0);
      imem_if.imem_rsp_ready = ($urandom_range(0, 3) != 0);
      imem_if.imem_rsp_data  = $urandom;
      rsp_f = imem_if.imem_rsp_valid && imem_if.imem_rsp_ready;
      imem_if.imem_req_ready = ($urandom_range(0, 1) == 1);
      imem_if.imem_req_valid = ((m_q.size() == 0) || rsp_f) && ($urandom_range(0, 1) == 1);
      #1;
      check("rnd_addr",  imem_if.imem_req_addr, m_pc);
      check("rnd_inst",  inst_dec, bubble_dec ? NOP : m_inst);
      check("rnd_pc",    pc_dec, m_pcq);
      check("rnd_valid", {31'd0, inst_dec_valid}, {31'd0, m_live && !bubble_dec});
      check("rnd_err",   {31'd0, fetch_err}, {31'd0, m_err});
      @(posedge clk);
      model_step();
      #1;
    end
`ifdef FETCH_PERF_CNT_EN
    check("rnd_cnt_fetched", cnt_fetched, m_fetched);
    check("rnd_cnt_dropped", cnt_dropped, m_dropped);
`endif

    // ---- PC wrap, LSB clear and reserved select ----
    do_reset();
    pc_we = 1'b1; pc_sel = 2'b10; alu_out = 32'hFFFF_FFFD;
    tick();
    check("wrap_redirect", imem_if.imem_req_addr, 32'hFFFF_FFFC);
    pc_sel = 2'b11;
    tick();
    check("sel11_hold", imem_if.imem_req_addr, 32'hFFFF_FFFC);
    pc_sel = 2'b01;
    tick();
    check("wrap_zero", imem_if.imem_req_addr, 32'h0);
    drive_idle();

    // ---- reset mid-request, then an orphan response in IDLE ----
    do_reset();
    imem_if.imem_req_valid = 1'b1; pc_we = 1'b1; pc_sel = 2'b01;
    tick();
    drive_idle();
    rst_n = 1'b0;
    #1;
    check("async_rst_addr", imem_if.imem_req_addr, 32'h0);
    tick();
    rst_n = 1'b1;
    imem_if.imem_rsp_valid = 1'b1; imem_if.imem_rsp_data = 32'h1234_5678;
    tick();
    imem_if.imem_rsp_valid = 1'b0;
    check("orphan_err",   {31'd0, fetch_err}, 32'd1);
    check("orphan_valid", {31'd0, inst_dec_valid}, 32'd0);
    check("orphan_inst",  inst_dec, NOP);
    repeat (3) tick();
    check("err_sticky", {31'd0, fetch_err}, 32'd1);
    do_reset();
    check_reset_state("rst2");

    // ---- second request while one is outstanding ----
    imem_if.imem_req_valid = 1'b1;
    tick();
    check("one_req_err", {31'd0, fetch_err}, 32'd0);
    tick();
    imem_if.imem_req_valid = 1'b0;
    check("dbl_req_err", {31'd0, fetch_err}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ama_riscv_fetch_dp.md
AMA_RISCV_FETCH_DP -- requirements
Module: ama_riscv_fetch_dp

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- RESET_VEC, 32'h0000_0000, PC value after reset
- NOP_INST, 32'h0000_0013, instruction presented to decode during a bubble (addi x0,x0,0)

REQ-002 Ports, one per line (name, direction, width, meaning):
- clk, in, 1, single clock; all state on rising edge
- rst_n, in, 1, asynchronous active-low reset
- pc_sel, in, 2, from fe_ctrl: 00 hold PC, 01 PC+4, 10 alu_out, 11 reserved (treated as hold)
- pc_we, in, 1, from fe_ctrl: PC register write enable
- bubble_dec, in, 1, from fe_ctrl: present NOP_INST to decode this cycle
- alu_out, in, 32, branch/jump target from execute
- imem_req_valid, in, 1, request valid as driven by fe_ctrl
- imem_req_ready, in, 1, imem accepts request
- imem_req_addr, out, 32, request byte address
- imem_rsp_valid, in, 1, imem response valid
- imem_rsp_ready, in, 1, response ready as driven by fe_ctrl
- imem_rsp_data, in, 32, fetched instruction
- inst_dec, out, 32, instruction to decode
- pc_dec, out, 32, PC of inst_dec
- inst_dec_valid, out, 1, inst_dec holds a live, non-bubble instruction
- fetch_err, out, 1, sticky protocol-error flag

Function
REQ-003 req_fire = imem_req_valid & imem_req_ready; rsp_fire = imem_rsp_valid & imem_rsp_ready.
REQ-004 PC register: on pc_we, PC <= (00/11: PC; 01: PC+4 modulo 2^32, 0xFFFF_FFFC wraps to 0; 10: alu_out with bit 0 forced to 0); otherwise hold.
REQ-005 imem_req_addr SHALL equal the current PC register combinationally.
REQ-006 On req_fire, req_pc <= PC (address of the outstanding request).
REQ-007 FSM states: IDLE (no request outstanding), WAIT (one live request outstanding), FLUSH (one stale request outstanding).
REQ-008 IDLE: req_fire -> WAIT; rsp_fire in IDLE -> set fetch_err, discard response, stay IDLE.
REQ-009 WAIT: rsp_fire -> capture response, then WAIT if req_fire in same cycle, else IDLE; no rsp_fire and redirect (pc_we & pc_sel==10) -> FLUSH; req_fire without rsp_fire -> set fetch_err, stay WAIT.
REQ-010 FLUSH: rsp_fire -> discard response (no capture), then WAIT if req_fire in same cycle, else IDLE; otherwise stay FLUSH.
REQ-011 Capture: inst_q <= imem_rsp_data, pc_q <= req_pc, live_q <= 1; outputs reflect capture one cycle after rsp_fire.
REQ-012 Redirect and rsp_fire in the same WAIT cycle: response is captured (it belongs to the pre-redirect stream, already resolved by fe_ctrl); no FLUSH.
REQ-013 inst_dec = bubble_dec ? NOP_INST : inst_q (combinational); pc_dec = pc_q always.
REQ-014 inst_dec_valid = live_q & !bubble_dec.
REQ-015 Without rsp_fire, inst_q, pc_q, live_q hold (decode stall retains instruction).
REQ-016 fetch_err is sticky until reset; at most one request outstanding at any time.

Reset
REQ-017 On rst_n low (asynchronous): PC=RESET_VEC, req_pc=RESET_VEC, state=IDLE, inst_q=NOP_INST, pc_q=RESET_VEC, live_q=0, fetch_err=0, counters=0.
REQ-018 Reset asserted mid-request: outstanding request forgotten; a response arriving after reset release in IDLE sets fetch_err per REQ-008.

Configuration
REQ-019 FETCH_PERF_CNT_EN defined: two 32-bit wrapping counters cnt_fetched (captures) and cnt_dropped (FLUSH discards), ports of the same names, out, 32; undefined: counters and ports absent, behaviour otherwise identical.

Verification
REQ-020 Reset release, pc_sel=01, pc_we=1 each cycle, imem 1-cycle response -> imem_req_addr 0x0,0x4,0x8; inst_dec/pc_dec follow one cycle after each rsp_fire.
REQ-021 Request at 0x10 outstanding, redirect to alu_out=0x101 -> FLUSH, response discarded, next imem_req_addr 0x100, pc_dec never 0x10.
REQ-022 Redirect coincident with rsp_fire in WAIT -> response captured, pc_dec=req_pc, state IDLE or WAIT, no drop.
REQ-023 bubble_dec=1 with live_q=1 -> inst_dec=0x0000_0013, inst_dec_valid=0, pc_dec unchanged; deassert -> original inst restored.
REQ-024 PC=0xFFFF_FFFC, pc_sel=01 -> PC=0x0; rsp_valid&ready while IDLE -> fetch_err=1, held until rst_n.
REQ-025 With FETCH_PERF_CNT_EN: 3 captures, 1 flush -> cnt_fetched=3, cnt_dropped=1.
